// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data memory behind a valid/ready request and response pair.
// Latency: the response is valid 1+WaitStates cycles after the accepting cycle, with one access in flight.
// Backpressure: req_ready_o is low outside IDLE, and the response is held stable until rsp_ready_i.
module data_mem_responder #(
    parameter int AddressWidth = 10,
    parameter int DataWidth    = 32,
    parameter int WaitStates   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_wr_i,
    input  logic [2:0]           req_funct3_i,
    input  logic [31:0]          req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_err_o
);
    localparam int Depth = 1 << AddressWidth;
    // Counter preload for the WAIT phase; the access happens in the cycle the counter reads zero.
    localparam logic [3:0] WaitLoad = (WaitStates == 0) ? 4'd0 : 4'(WaitStates - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic                 wr;
        logic [2:0]           funct3;
        logic [31:0]          addr;
        logic [DataWidth-1:0] wdata;
    } req_t;

    state_e                  state_q;
    state_e                  state_d;
    logic [3:0]              cnt_q;
    req_t                    req_in;
    req_t                    req_q;
    req_t                    acc;
    logic                    accept;
    logic                    acc_fire;
    logic                    acc_err;
    logic [3:0]              acc_be;
    logic [DataWidth-1:0]    acc_wdat;
    logic [AddressWidth-1:0] acc_idx;
    logic                    mem_we;
    logic [DataWidth-1:0]    rdata_q;
    logic                    err_q;
    logic [DataWidth-1:0]    mem [Depth];

    // Address bits above the word index alias onto the same storage and are deliberately dropped.
    logic unused_addr_hi;

    assign req_in = '{wr: req_wr_i, funct3: req_funct3_i, addr: req_addr_i, wdata: req_wdata_i};
    assign accept = req_valid_i & req_ready_o;

    // With no wait states the access uses the live request at the accepting edge;
    // otherwise it uses the copy latched at acceptance.
    assign acc            = (state_q == IDLE) ? req_in : req_q;
    assign acc_idx        = acc.addr[AddressWidth+1:2];
    assign unused_addr_hi = ^acc.addr[31:AddressWidth+2];

    // A reset on the commit edge wins, so a pending store is never written.
    assign mem_we = acc_fire & acc.wr & ~acc_err & ~rst_i;

    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (WaitStates == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs: handshake flags and the single-cycle access strobe.
    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        acc_fire    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                acc_fire    = req_valid_i & (WaitStates == 0);
            end
            WAIT: begin
                acc_fire = (cnt_q == 4'd0);
            end
            RESP: begin
                rsp_valid_o = 1'b1;
            end
            default: begin
                req_ready_o = 1'b0;
            end
        endcase
    end

    // Size decode: byte enables, replicated store data and the error check.
    always_comb begin
        acc_err  = 1'b0;
        acc_be   = 4'b0000;
        acc_wdat = acc.wdata;
        case (acc.funct3)
            3'b000, 3'b100: begin
                acc_be   = 4'b0001 << acc.addr[1:0];
                acc_wdat = {4{acc.wdata[7:0]}};
                acc_err  = acc.wr & acc.funct3[2];
            end
            3'b001, 3'b101: begin
                acc_be   = acc.addr[1] ? 4'b1100 : 4'b0011;
                acc_wdat = {2{acc.wdata[15:0]}};
                acc_err  = acc.addr[0] | (acc.wr & acc.funct3[2]);
            end
            3'b010: begin
                acc_be  = 4'b1111;
                acc_err = (acc.addr[1:0] != 2'b00);
            end
            default: begin
                acc_err = 1'b1;
            end
        endcase
    end

    // Request latch, wait counter and response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q   <= '0;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                req_q <= req_in;
                cnt_q <= WaitLoad;
            end else if (state_q == WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (acc_fire) begin
                err_q   <= acc_err;
                rdata_q <= (acc.wr | acc_err) ? '0 : mem[acc_idx];
            end
        end
    end

    // Byte-lane storage write; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem[acc_idx][b*8 +: 8] <= acc_wdat[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks of data_mem_responder against a byte-level memory model.
// Latency: one instance with two wait states and one instance with none.
// Backpressure: response stalls and back-to-back streams are both exercised.
module tb_data_mem_responder;
    localparam int WS_A = 2;
    localparam int NB   = 8;

    logic        clk;
    logic        rst;

    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        req_valid_b;
    logic        req_ready_b;
    logic        req_wr_b;
    logic [2:0]  req_funct3_b;
    logic [31:0] req_addr_b;
    logic [31:0] req_wdata_b;
    logic        rsp_valid_b;
    logic        rsp_ready_b;
    logic [31:0] rsp_rdata_b;
    logic        rsp_err_b;

    int total = 0;
    int bad   = 0;

    // Reference memory, indexed by word and shared by both instances on disjoint words.
    logic [31:0] mdl [0:1023];

    logic        b_wr [NB] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0]  b_f3 [NB] = '{3'd2, 3'd2, 3'd0, 3'd2, 3'd2, 3'd1, 3'd2, 3'd2};
    logic [31:0] b_ad [NB] = '{32'h40, 32'h40, 32'h41, 32'h40, 32'h44, 32'h46, 32'h44, 32'h43};
    logic [31:0] b_wd [NB];

    data_mem_responder #(.AddressWidth(10), .DataWidth(32), .WaitStates(WS_A)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wr_i(req_wr),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
    );

    data_mem_responder #(.AddressWidth(10), .DataWidth(32), .WaitStates(0)) u_dut_ws0 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid_b), .req_ready_o(req_ready_b), .req_wr_i(req_wr_b),
        .req_funct3_i(req_funct3_b), .req_addr_i(req_addr_b), .req_wdata_i(req_wdata_b),
        .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready_b),
        .rsp_rdata_o(rsp_rdata_b), .rsp_err_o(rsp_err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Access rules: size 1/2/4 bytes from funct3[1:0], natural alignment,
    // no unsigned stores, and 011/110/111 are illegal.
    task automatic model_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int size;
        int idx;
        int off;
        logic [31:0] w;
        idx = int'((addr >> 2) % 1024);
        off = int'(addr % 4);
        case (f3[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        er = (size == 0) || (f3 == 3'b110) || (wr && f3[2]);
        if (size != 0 && (off % size) != 0) er = 1'b1;
        rd = 32'h0;
        if (!er) begin
            if (wr) begin
                w = mdl[idx];
                for (int k = 0; k < size; k++) w[(off+k)*8 +: 8] = wd[k*8 +: 8];
                mdl[idx] = w;
            end else begin
                rd = mdl[idx];
            end
        end
    endtask

    // One complete transaction on the two-wait-state instance, with `stall` cycles of response backpressure.
    task automatic xact(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int stall, output logic [31:0] rd);
        logic [31:0] exp_d;
        logic        exp_e;
        int          n;
        model_access(wr, f3, addr, wd, exp_d, exp_e);
        req_wr     = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rdy_wait", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wr    = ~wr;
        n = 1;
        while (!rsp_valid && n < 40) begin
            chk("rdy_busy", req_ready, 0);
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, 1 + WS_A);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("hold_vld", rsp_valid, 1);
            chk("hold_dat", rsp_rdata, exp_d);
            chk("hold_err", rsp_err, exp_e);
            chk("hold_rdy", req_ready, 0);
        end
        chk("rdata", rsp_rdata, exp_d);
        chk("err", rsp_err, exp_e);
        rd = rsp_rdata;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("idle_vld", rsp_valid, 0);
        chk("idle_rdy", req_ready, 1);
    endtask

    // Back-to-back stream on the zero-wait-state instance with the response always consumed.
    task automatic run_ws0();
        int          cyc;
        int          last_acc;
        int          nacc;
        int          nrsp;
        logic        acc;
        logic [31:0] ed;
        logic        ee;
        logic [31:0] q_d [$];
        logic        q_e [$];
        int          q_c [$];
        for (int i = 0; i < NB; i++) b_wd[i] = $urandom;
        req_wr_b     = b_wr[0];
        req_funct3_b = b_f3[0];
        req_addr_b   = b_ad[0];
        req_wdata_b  = b_wd[0];
        req_valid_b  = 1'b1;
        rsp_ready_b  = 1'b1;
        cyc = 0; last_acc = -1; nacc = 0; nrsp = 0;
        while (nrsp < NB && cyc < 100) begin
            acc = req_valid_b & req_ready_b;
            if (rsp_valid_b) begin
                if (q_d.size() == 0) begin
                    chk("b_spurious", 1, 0);
                end else begin
                    chk("b_rdata", rsp_rdata_b, q_d.pop_front());
                    chk("b_err", rsp_err_b, q_e.pop_front());
                    chk("b_lat", cyc - q_c.pop_front(), 1);
                end
                nrsp++;
            end
            if (acc) begin
                model_access(b_wr[nacc], b_f3[nacc], b_ad[nacc], b_wd[nacc], ed, ee);
                q_d.push_back(ed);
                q_e.push_back(ee);
                q_c.push_back(cyc);
                if (last_acc >= 0) chk("b_gap", cyc - last_acc, 2);
                last_acc = cyc;
                nacc++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (nacc < NB) begin
                    req_wr_b     = b_wr[nacc];
                    req_funct3_b = b_f3[nacc];
                    req_addr_b   = b_ad[nacc];
                    req_wdata_b  = b_wd[nacc];
                end else begin
                    req_valid_b = 1'b0;
                end
            end
        end
        chk("b_count", nrsp, NB);
        rsp_ready_b = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [2:0]  f3;
        int          r;
        rst = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        rsp_ready = 1'b0;
        req_valid_b = 1'b0; req_wr_b = 1'b0; req_funct3_b = 3'd0; req_addr_b = 32'h0; req_wdata_b = 32'h0;
        rsp_ready_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_rdy", req_ready, 1);
        chk("rst_vld", rsp_valid, 0);
        chk("rst_dat", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_rdy_b", req_ready_b, 1);
        chk("rst_vld_b", rsp_valid_b, 0);

        // Give the words used by the random phase a known value.
        for (int i = 0; i < 16; i++) xact(1'b1, 3'd2, 32'(i * 4), $urandom, 0, rd);

        xact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd);
        chk("sw_rdata0", rd, 32'h0);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd);
        chk("lw_deadbeef", rd, 32'hDEADBEEF);

        xact(1'b1, 3'd0, 32'h11, {$urandom_range(0, 32'hFFFFFF), 8'h55}, 1, rd);
        xact(1'b1, 3'd1, 32'h12, {16'h1234, 16'hA5A5}, 0, rd);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd);
        chk("lw_merge", rd, 32'hA5A555EF);

        xact(1'b0, 3'd2, 32'h12, 32'h0, 0, rd);
        chk("lw_misal_dat", rd, 32'h0);
        xact(1'b1, 3'd1, 32'h13, 32'hFFFF_FFFF, 0, rd);
        xact(1'b1, 3'd4, 32'h10, 32'hFFFF_FFFF, 0, rd);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd);
        chk("lw_unchanged", rd, 32'hA5A555EF);

        xact(1'b0, 3'd2, 32'h10, 32'h0, 5, rd);

        // Reset lands on the commit edge of a pending store.
        req_wr = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        chk("wr_rdy", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("wr_wait", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_rdy", req_ready, 1);
        chk("mid_rst_vld", rsp_valid, 0);
        chk("mid_rst_dat", rsp_rdata, 0);
        chk("mid_rst_err", rsp_err, 0);
        xact(1'b0, 3'd2, 32'h20, 32'h0, 0, rd);

        xact(1'b1, 3'd2, 32'h1010, 32'hCAFEF00D, 0, rd);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd);
        chk("alias", rd, 32'hCAFEF00D);

        for (int i = 0; i < 200; i++) begin
            r  = int'($urandom_range(0, 9));
            f3 = (r < 8) ? 3'(r) : 3'd2;
            xact(1'($urandom_range(0, 1)), f3,
                 ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)),
                 $urandom, int'($urandom_range(0, 3)), rd);
        end

        run_ws0();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter AddressWidth, default 10, word-address width; storage is 2^AddressWidth 32-bit words.
REQ-002 SHALL have parameter DataWidth, default 32, data word width; only 32 is supported.
REQ-003 SHALL have parameter WaitStates, default 2, extra access-latency cycles; legal range 0-15.
REQ-004 SHALL have port clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port req_valid_i, input, 1, request present.
REQ-007 SHALL have port req_ready_o, output, 1, responder can accept a request.
REQ-008 SHALL have port req_wr_i, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port req_funct3_i, input, 3, RV32I size code: 000/100 byte, 001/101 half, 010 word.
REQ-010 SHALL have port req_addr_i, input, 32, byte address.
REQ-011 SHALL have port req_wdata_i, input, 32, store data, right-justified (rs2 value).
REQ-012 SHALL have port rsp_valid_o, output, 1, response present.
REQ-013 SHALL have port rsp_ready_i, input, 1, requester consumes response.
REQ-014 SHALL have port rsp_rdata_o, output, 32, raw aligned word for loads; sign/zero extension is done by the core.
REQ-015 SHALL have port rsp_err_o, output, 1, request rejected as misaligned or illegal.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP; req_ready_o = 1 only in IDLE, and rsp_valid_o = 1 only in RESP.
REQ-017 SHALL accept a request in IDLE on req_valid_i & req_ready_o, latching wr, funct3, addr and wdata.
REQ-018 SHALL, when WaitStates = 0, perform the access at the acceptance edge and enter RESP; otherwise it SHALL enter WAIT with the counter loaded to WaitStates-1.
REQ-019 SHALL, in WAIT, decrement the counter each cycle; when the counter = 0, it SHALL perform the access from latched values and enter RESP.
REQ-020 SHALL assert rsp_valid_o exactly 1+WaitStates cycles after the acceptance cycle.
REQ-021 SHALL hold rsp_rdata_o and rsp_err_o stable in RESP until rsp_valid_o & rsp_ready_i, then return to IDLE; no new request is accepted in that same cycle.
REQ-022 SHALL index storage by word index addr[AddressWidth+1:2]; upper address bits are ignored and alias (wrap-around).
REQ-023 SHALL write stores by byte lane: SB writes lane addr[1:0] with wdata[7:0]; SH writes lanes addr[1]*2..+1 with wdata[15:0]; SW writes all lanes; unselected lanes are unchanged.
REQ-024 SHALL, for loads, return the full stored word at the word index in rsp_rdata_o; for stores, rsp_rdata_o = 0.
REQ-025 SHALL flag an error when the access is half with addr[0]=1, word with addr[1:0]≠0, a store with funct3[2]=1, or funct3 ∈ {011,110,111}.
REQ-026 SHALL, on error, perform no write, drive rsp_rdata_o = 0 and rsp_err_o = 1, with latency unchanged.
REQ-027 SHALL make a load issued after a completed store to the same word return the updated data.
REQ-028 SHALL ignore req_valid_i outside IDLE; the requester holds the request until accepted.

Reset
REQ-029 SHALL, on rst_i = 1 at a clock edge, enter IDLE and clear the counter, rsp_valid_o, rsp_rdata_o and rsp_err_o to 0; req_ready_o SHALL be 1 after the reset edge.
REQ-030 SHALL NOT clear storage contents on reset.
REQ-031 SHALL discard, on reset during WAIT, a store that has not yet been committed, and SHALL drop any pending response.
REQ-032 SHALL give rst_i priority over a simultaneous handshake.

Verification
REQ-033 SHALL verify: WaitStates=2, SW 0xDEADBEEF @0x10 accepted cycle T, then LW @0x10 -> rsp_valid at T+3 for both; load rdata = 0xDEADBEEF, err = 0.
REQ-034 SHALL verify: after that store, SB 0x55 @0x11 and SH 0xA5A5 @0x12, then LW @0x10 -> rdata = 0xA5A555EF.
REQ-035 SHALL verify: LW @0x12 and SH @0x13 -> err = 1, rdata = 0, and a subsequent LW @0x10 shows memory unchanged.
REQ-036 SHALL verify: rsp_ready_i held low 5 cycles in RESP -> rsp_valid, rdata and err stable and req_ready_o = 0 throughout; handshake returns to IDLE next cycle.
REQ-037 SHALL verify: rst_i pulsed during WAIT of SW 0x12345678 @0x20 -> outputs reset, a later LW @0x20 returns the pre-store value; with AddressWidth=10, SW @0x1010 aliases @0x10.
REQ-038 SHALL verify: WaitStates=0, back-to-back requests with rsp_ready_i=1 -> rsp_valid one cycle after each acceptance, and one request accepted every 2 cycles.
